adc_sample_scheduler: RTL and testbench

//  Sequences XADC DRP reads for the voltage (VT, aux6) and current (CT, aux7) channels at a fixed

---
 rtl/adc_sample_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: paced XADC DRP reader for the VT (aux6) and CT
// (aux7) channels. Each sample tick reads both channels back-to-back and
// emits the pair on one strobe, together with a frame buffer index.
// Optional drdy watchdog: define ADC_SCHED_TIMEOUT_EN.
// Ports: clk, rst (sync, active-high), run, drdy, do_in[15:0] in;
//   den, daddr[6:0], vt_start, vt_sample[15:0], ct_start, ct_sample[15:0],
//   sample_idx[IDX_W-1:0], frame_done, overrun, timeout_err, busy out.
module adc_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV = 78125,
  parameter logic [6:0]  VT_ADDR    = 7'h16,
  parameter logic [6:0]  CT_ADDR    = 7'h17,
  parameter int unsigned FRAME_LEN  = 512,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned IDX_W = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             drdy,
  input  logic [15:0]      do_in,
  output logic             den,
  output logic [6:0]       daddr,
  output logic             vt_start,
  output logic [15:0]      vt_sample,
  output logic             ct_start,
  output logic [15:0]      ct_sample,
  output logic [IDX_W-1:0] sample_idx,
  output logic             frame_done,
  output logic             overrun,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_VT,
    S_WT_VT,
    S_RD_CT,
    S_WT_CT,
    S_EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        vt_hold_q, vt_hold_d;
  logic               den_q, den_d;
  logic [6:0]         daddr_q, daddr_d;
  logic               strobe_q, strobe_d;
  logic [15:0]        vt_sample_q, vt_sample_d;
  logic [15:0]        ct_sample_q, ct_sample_d;
  logic [IDX_W-1:0]   sample_idx_q, sample_idx_d;
  logic               frame_done_q, frame_done_d;
  logic               tick;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;
  logic               wd_exp;
  // wd_q counts cycles since the last den; expiry lands the error
  // pulse exactly TIMEOUT cycles after den.
  assign wd_exp = (wd_q == WD_W'(TIMEOUT - 1)) && !drdy;
`endif

  assign tick = run && (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = (!run || tick) ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    vt_hold_d    = vt_hold_q;
    den_d        = 1'b0;
    daddr_d      = daddr_q;
    strobe_d     = 1'b0;
    vt_sample_d  = vt_sample_q;
    ct_sample_d  = ct_sample_q;
    sample_idx_d = sample_idx_q;
    frame_done_d = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_RD_VT;
          den_d   = 1'b1;
          daddr_d = VT_ADDR;
        end
      end
      S_RD_VT: state_d = S_WT_VT;
      S_WT_VT: begin
        if (drdy) begin
          vt_hold_d = do_in;
          state_d   = S_RD_CT;
          den_d     = 1'b1;
          daddr_d   = CT_ADDR;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        else if (wd_exp) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end
`endif
      end
      S_RD_CT: state_d = S_WT_CT;
      S_WT_CT: begin
        if (drdy) begin
          // Strobe and sample words are registered together so the
          // pair appears in the EMIT cycle.
          state_d      = S_EMIT;
          strobe_d     = 1'b1;
          vt_sample_d  = vt_hold_q;
          ct_sample_d  = do_in;
          sample_idx_d = idx_q;
          frame_done_d = (idx_q == IDX_W'(FRAME_LEN - 1));
          idx_d        = idx_q + 1'b1;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        else if (wd_exp) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end
`endif
      end
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ADC_SCHED_TIMEOUT_EN
    if (den_d)
      wd_d = '0;
    else if (wd_q == WD_W'(TIMEOUT))
      wd_d = wd_q;
    else
      wd_d = wd_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      vt_hold_q    <= '0;
      den_q        <= 1'b0;
      daddr_q      <= VT_ADDR;
      strobe_q     <= 1'b0;
      vt_sample_q  <= '0;
      ct_sample_q  <= '0;
      sample_idx_q <= '0;
      frame_done_q <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      vt_hold_q    <= vt_hold_d;
      den_q        <= den_d;
      daddr_q      <= daddr_d;
      strobe_q     <= strobe_d;
      vt_sample_q  <= vt_sample_d;
      ct_sample_q  <= ct_sample_d;
      sample_idx_q <= sample_idx_d;
      frame_done_q <= frame_done_d;
`ifdef ADC_SCHED_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign den        = den_q;
  assign daddr      = daddr_q;
  assign vt_start   = strobe_q;
  assign ct_start   = strobe_q;
  assign vt_sample  = vt_sample_q;
  assign ct_sample  = ct_sample_q;
  assign sample_idx = sample_idx_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  // A tick in any non-IDLE cycle, EMIT included, is dropped.
  assign overrun    = tick && busy;
`ifdef ADC_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: event-schedule reference model, vector table
// and directed corner sequences for adc_sample_scheduler.
module tb_adc_sample_scheduler;

  localparam int DIV = 16;
  localparam int FL  = 512;
  localparam int TO  = 8;
  localparam logic [6:0] VA = 7'h16;
  localparam logic [6:0] CA = 7'h17;

  logic        clk = 1'b0;
  logic        rst, run, drdy;
  logic [15:0] do_in;
  logic        den, vt_start, ct_start;
  logic [6:0]  daddr;
  logic [15:0] vt_sample, ct_sample;
  logic [8:0]  sample_idx;
  logic        frame_done, overrun, timeout_err, busy;

  adc_sample_scheduler #(
    .SAMPLE_DIV(DIV),
    .FRAME_LEN (FL),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .drdy(drdy), .do_in(do_in),
    .den(den), .daddr(daddr),
    .vt_start(vt_start), .vt_sample(vt_sample),
    .ct_start(ct_start), .ct_sample(ct_sample),
    .sample_idx(sample_idx), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: one sequence described by its event cycles
  bit          mvalid = 0;
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [6:0]  m_daddr = VA;
  logic [15:0] last_vt = 0, last_ct = 0;
  int          last_idx = 0;
  bit          seq_act = 0;
  int          s_tick, s_dv_at, s_ct_den, s_ct_drdy, s_emit, s_end;
  logic [15:0] s_vt, s_ct;
  int          to_at = -1;
  int          ghost = -1;

  bit          plan_set = 0;
  bit          p_hold = 0;
  int          p_dv, p_dc;
  logic [15:0] p_vt, p_ct;

  int n_ovr = 0, n_st = 0, n_den = 0, n_fd = 0;

  typedef struct {
    int dv; int dc;
    logic [15:0] vt; logic [15:0] ct;
    int off;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit rn);
    bit busy_e, tick_e, den_e, st_e, fd_e, hold;
    int dv, dc;
    logic [15:0] vv, cv;
    rst = r;
    run = rn;
    busy_e = seq_act && cyc >= s_tick + 1 && cyc <= s_end;
    drdy = 1'b0;
    do_in = 16'($urandom);
    if (seq_act && cyc == s_dv_at) begin
      drdy = 1'b1; do_in = s_vt;
    end else if (seq_act && cyc == s_ct_drdy) begin
      drdy = 1'b1; do_in = s_ct;
    end else if (cyc == ghost) begin
      drdy = 1'b1;
    end else if (!busy_e && $urandom_range(0, 3) == 0) begin
      drdy = 1'b1;
    end
    #1;
    den_e = seq_act && (cyc == s_tick + 1 || cyc == s_ct_den);
    if (seq_act && cyc == s_tick + 1) m_daddr = VA;
    if (seq_act && cyc == s_ct_den) m_daddr = CA;
    st_e = seq_act && cyc == s_emit;
    fd_e = 0;
    if (st_e) begin
      last_vt = s_vt;
      last_ct = s_ct;
      last_idx = m_idx;
      fd_e = (m_idx == FL - 1);
      m_idx = (m_idx + 1) % FL;
    end
    tick_e = rn && m_cnt == DIV - 1;
    if (overrun) n_ovr++;
    if (vt_start) n_st++;
    if (den) n_den++;
    if (frame_done) n_fd++;
    if (mvalid) begin
      chk("den", den, den_e);
      chk("daddr", daddr, m_daddr);
      chk("vt_start", vt_start, st_e);
      chk("ct_start", ct_start, st_e);
      chk("vt_sample", vt_sample, last_vt);
      chk("ct_sample", ct_sample, last_ct);
      chk("sample_idx", sample_idx, last_idx);
      chk("frame_done", frame_done, fd_e);
      chk("overrun", overrun, tick_e && busy_e);
      chk("busy", busy, busy_e);
      chk("timeout_err", timeout_err, cyc == to_at);
    end
    if (r) begin
      if (seq_act && s_ct_drdy > cyc) ghost = s_ct_drdy;
      seq_act = 0; to_at = -1; m_cnt = 0; m_idx = 0;
      last_vt = 0; last_ct = 0; last_idx = 0;
      m_daddr = VA; mvalid = 1;
    end else begin
      if (seq_act && cyc == s_end) seq_act = 0;
      if (tick_e && !busy_e) begin
        if (plan_set) begin
          dv = p_dv; dc = p_dc; vv = p_vt; cv = p_ct;
          hold = p_hold; plan_set = 0; p_hold = 0;
        end else begin
          dv = $urandom_range(1, 6);
          dc = $urandom_range(1, 6);
          vv = 16'($urandom); cv = 16'($urandom);
          hold = 0;
        end
        seq_act = 1; s_tick = cyc; s_vt = vv; s_ct = cv;
        if (hold) begin
          s_dv_at = -1; s_ct_den = -1; s_ct_drdy = -1;
          s_emit = -1; to_at = cyc + 1 + TO; s_end = to_at - 1;
        end else begin
          s_dv_at = cyc + 1 + dv;
          s_ct_den = s_dv_at + 1;
          s_ct_drdy = s_ct_den + dc;
          s_emit = s_ct_drdy + 1;
          s_end = s_emit;
        end
      end
      m_cnt = rn ? (m_cnt + 1) % DIV : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input string nm);
    int b = 0;
    while (seq_act && b < 100) begin
      step(0, 1);
      b++;
    end
    chk(nm, seq_act, 0);
  endtask

  task automatic set_plan(input int dv, input int dc,
                          input logic [15:0] vv,
                          input logic [15:0] cv);
    p_dv = dv; p_dc = dc; p_vt = vv; p_ct = cv;
    plan_set = 1;
  endtask

  initial begin
    int base, b, o0, s0, d0, f0, r0;
    tbl[0] = '{1, 1, 16'h0001, 16'hfffe, 5};
    tbl[1] = '{2, 4, 16'ha5a5, 16'h5a5a, 9};
    tbl[2] = '{6, 6, 16'h8000, 16'h7fff, 15};
    tbl[3] = '{5, 1, 16'h1234, 16'h0000, 9};
    rst = 1; run = 0; drdy = 0; do_in = 0;
    @(posedge clk);
    #1;
    repeat (3) step(1, 1);
    chk("rst_den", den, 0);
    chk("rst_daddr", daddr, VA);
    chk("rst_idx", sample_idx, 0);
    chk("rst_busy", busy, 0);

    // T1: basic timing
    set_plan(3, 3, 16'h1230, 16'h4560);
    base = cyc;
    while (cyc - base <= 26) begin
      if (cyc - base == 16) begin
        chk("t1_den_vt", den, 1);
        chk("t1_addr_vt", daddr, VA);
      end
      if (cyc - base == 20) begin
        chk("t1_den_ct", den, 1);
        chk("t1_addr_ct", daddr, CA);
      end
      if (cyc - base == 24) begin
        chk("t1_strobe", {vt_start, ct_start}, 2'b11);
        chk("t1_vt", vt_sample, 16'h1230);
        chk("t1_ct", ct_sample, 16'h4560);
        chk("t1_idx", sample_idx, 0);
      end
      step(0, 1);
    end

    // vector table: drdy delays vs strobe latency
    foreach (tbl[i]) begin
      wait_idle("tbl_idle");
      set_plan(tbl[i].dv, tbl[i].dc, tbl[i].vt, tbl[i].ct);
      b = 0;
      while (!(vt_start && !plan_set) && b < 60) begin
        step(0, 1);
        b++;
      end
      chk("tbl_strobe_seen", b < 60, 1);
      chk("tbl_latency", cyc - s_tick, tbl[i].off);
      chk("tbl_vt", vt_sample, tbl[i].vt);
      chk("tbl_ct", ct_sample, tbl[i].ct);
    end

    // T2: long random run across the frame wrap
    f0 = n_fd;
    repeat (FL * DIV + 300) step(0, 1);
    chk("t2_frame_done_seen", n_fd > f0, 1);

    // T3: slow drdy -> two dropped ticks, one emit
    wait_idle("t3_idle");
    set_plan(20, 20, 16'hbeef, 16'hcafe);
    o0 = n_ovr; s0 = n_st; b = 0;
    while ((plan_set || seq_act) && b < 120) begin
      step(0, 1);
      b++;
    end
    chk("t3_overruns", n_ovr - o0, 2);
    chk("t3_emits", n_st - s0, 1);

    // T4: reset while waiting for the CT word
    wait_idle("t4_idle");
    set_plan(2, 10, 16'h1111, 16'h2222);
    b = 0;
    while (!(seq_act && !plan_set && cyc == s_ct_den + 3) && b < 60) begin
      step(0, 1);
      b++;
    end
    chk("t4_reached", b < 60, 1);
    step(1, 1);
    chk("t4_den", den, 0);
    chk("t4_busy", busy, 0);
    chk("t4_idx", sample_idx, 0);
    s0 = n_st;
    repeat (12) step(0, 1);
    chk("t4_no_strobe", n_st - s0, 0);

`ifdef ADC_SCHED_TIMEOUT_EN
    // T5: withheld drdy -> watchdog
    wait_idle("t5_idle");
    set_plan(1, 1, 16'h0, 16'h0);
    p_hold = 1;
    b = 0;
    while (!(to_at >= 0 && cyc == to_at) && b < 60) begin
      step(0, 1);
      b++;
    end
    chk("t5_timeout", timeout_err, 1);
    chk("t5_no_strobe", vt_start, 0);
    chk("t5_busy", busy, 0);
    repeat (40) step(0, 1);
`endif

    // T6: drop run mid-sequence
    wait_idle("t6_idle");
    b = 0;
    while (!(seq_act && cyc == s_tick + 3) && b < 60) begin
      step(0, 1);
      b++;
    end
    s0 = n_st; d0 = n_den;
    repeat (60) step(0, 0);
    chk("t6_emit", n_st - s0, 1);
    chk("t6_den", n_den - d0, 1);
    r0 = cyc; b = 0;
    while (!den && b < 40) begin
      step(0, 1);
      b++;
    end
    chk("t6_restart", cyc - r0, 16);
    repeat (40) step(0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
